// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/status bundle between multicycle_ctrl and the shared datapath
interface multicycle_ctrl_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        pc_we;
  logic        ir_we;
  logic        mem_rd;
  logic        mem_we;
  logic        iord;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wb_sel;
  logic        alu_a_sel;
  logic [1:0]  alu_b_sel;
  logic [2:0]  alu_op;
  logic        ext_op;
  logic [1:0]  pc_src;
  logic        instr_done;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] instr_count;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, ir_we, mem_rd, mem_we, iord, reg_we, reg_dst, wb_sel,
           alu_a_sel, alu_b_sel, alu_op, ext_op, pc_src, instr_done, illegal,
           state, instr_count
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, ir_we, mem_rd, mem_we, iord, reg_we, reg_dst, wb_sel,
           alu_a_sel, alu_b_sel, alu_op, ext_op, pc_src, instr_done, illegal,
           state, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM with memory stall and retire counter
module multicycle_ctrl (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    ALU_WB   = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    MEM_WB   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JAL      = 4'd12,
    JR       = 4'd13,
    TRAP     = 4'd14
  } state_t;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_LUI  = 3'b111;
  localparam logic [2:0] ALU_SLL  = 3'b011;

  state_t      state_q, state_d;
  logic [31:0] count_q;
  logic        done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Wraps naturally at 32 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count_q <= 32'd0;
    else if (done) count_q <= count_q + 32'd1;
  end

  assign bus.state       = state_q;
  assign bus.instr_count = count_q;
  assign bus.instr_done  = done;
  assign bus.illegal     = (state_q == TRAP);

  always_comb begin
    state_d       = state_q;
    done          = 1'b0;
    bus.pc_we     = 1'b0;
    bus.ir_we     = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.iord      = 1'b0;
    bus.reg_we    = 1'b0;
    bus.reg_dst   = 2'd0;
    bus.wb_sel    = 2'd0;
    bus.alu_a_sel = 1'b0;
    bus.alu_b_sel = 2'd0;
    bus.alu_op    = ALU_NONE;
    bus.ext_op    = 1'b0;
    bus.pc_src    = 2'd0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        bus.mem_rd    = 1'b1;
        bus.alu_b_sel = 2'd1;
        bus.alu_op    = ALU_ADD;
        bus.pc_we     = bus.mem_ready;
        bus.ir_we     = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        // Speculatively compute the branch target into ALUOut
        bus.alu_b_sel = 2'd3;
        bus.alu_op    = ALU_ADD;
        case (bus.opcode)
          6'h00: begin
            if (bus.funct == 6'h21 || bus.funct == 6'h23 || bus.funct == 6'h00)
              state_d = EXEC_R;
            else if (bus.funct == 6'h08)
              state_d = JR;
            else
              state_d = TRAP;
          end
          6'h0D, 6'h0F: state_d = EXEC_I;
          6'h23, 6'h2B: state_d = MEM_ADDR;
          6'h04:        state_d = BRANCH;
          6'h02:        state_d = JUMP;
          6'h03:        state_d = JAL;
          default:      state_d = TRAP;
        endcase
      end
      EXEC_R: begin
        bus.alu_a_sel = 1'b1;
        case (bus.funct)
          6'h21:   bus.alu_op = ALU_ADD;
          6'h23:   bus.alu_op = ALU_SUB;
          default: bus.alu_op = ALU_SLL;
        endcase
        state_d = ALU_WB;
      end
      EXEC_I: begin
        bus.alu_a_sel = 1'b1;
        bus.alu_b_sel = 2'd2;
        if (bus.opcode == 6'h0D) begin
          bus.alu_op = ALU_OR;
          bus.ext_op = 1'b1;
        end else begin
          bus.alu_op = ALU_LUI;
        end
        state_d = ALU_WB;
      end
      ALU_WB: begin
        bus.reg_we  = 1'b1;
        bus.reg_dst = (bus.opcode == 6'h00) ? 2'd1 : 2'd0;
        done        = 1'b1;
        state_d     = FETCH;
      end
      MEM_ADDR: begin
        bus.alu_a_sel = 1'b1;
        bus.alu_b_sel = 2'd2;
        bus.alu_op    = ALU_ADD;
        state_d       = (bus.opcode == 6'h23) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        bus.mem_rd = 1'b1;
        bus.iord   = 1'b1;
        if (bus.mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        bus.reg_we = 1'b1;
        bus.wb_sel = 2'd1;
        done       = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        bus.mem_we = 1'b1;
        bus.iord   = 1'b1;
        done       = bus.mem_ready;
        if (bus.mem_ready) state_d = FETCH;
      end
      BRANCH: begin
        bus.alu_a_sel = 1'b1;
        bus.alu_op    = ALU_SUB;
        bus.pc_src    = 2'd1;
        bus.pc_we     = bus.zero;
        done          = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        bus.pc_src = 2'd2;
        bus.pc_we  = 1'b1;
        done       = 1'b1;
        state_d    = FETCH;
      end
      JAL: begin
        // PC already holds PC+4, so $31 gets the return address
        bus.pc_src  = 2'd2;
        bus.pc_we   = 1'b1;
        bus.reg_we  = 1'b1;
        bus.reg_dst = 2'd2;
        bus.wb_sel  = 2'd2;
        done        = 1'b1;
        state_d     = FETCH;
      end
      JR: begin
        bus.pc_src = 2'd3;
        bus.pc_we  = 1'b1;
        done       = 1'b1;
        state_d    = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  multicycle_ctrl_if bus ();
  multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3, S_EXEC_I = 4,
                 S_ALU_WB = 5, S_MEM_ADDR = 6, S_MEM_RD = 7, S_MEM_WB = 8, S_MEM_WR = 9,
                 S_BRANCH = 10, S_JUMP = 11, S_JAL = 12, S_JR = 13, S_TRAP = 14;

  logic [31:0] exp_count;
  logic [20:0] snap [15];
  int          trace [$];

  // Outputs packed as {pc_we, ir_we, mem_rd, mem_we, iord, reg_we, reg_dst, wb_sel,
  //                    alu_a_sel, alu_b_sel, alu_op, ext_op, pc_src, instr_done, illegal}
  function automatic logic [20:0] dut_outs();
    return {bus.pc_we, bus.ir_we, bus.mem_rd, bus.mem_we, bus.iord, bus.reg_we,
            bus.reg_dst, bus.wb_sel, bus.alu_a_sel, bus.alu_b_sel, bus.alu_op,
            bus.ext_op, bus.pc_src, bus.instr_done, bus.illegal};
  endfunction

  function automatic logic [20:0] model(int s, logic [5:0] op, logic [5:0] fn, logic z, logic rdy);
    logic pc_we = 0, ir_we = 0, mrd = 0, mwe = 0, iord = 0, rwe = 0, asel = 0, ext = 0;
    logic done = 0, ill = 0;
    logic [1:0] rdst = 0, wb = 0, bsel = 0, psrc = 0;
    logic [2:0] aop = 0;
    case (s)
      S_FETCH:    begin mrd = 1; bsel = 1; aop = 3'b010; pc_we = rdy; ir_we = rdy; end
      S_DECODE:   begin bsel = 3; aop = 3'b010; end
      S_EXEC_R:   begin asel = 1; aop = (fn == 6'h21) ? 3'b010 : (fn == 6'h23) ? 3'b110 : 3'b011; end
      S_EXEC_I:   begin asel = 1; bsel = 2; aop = (op == 6'h0D) ? 3'b001 : 3'b111; ext = (op == 6'h0D); end
      S_ALU_WB:   begin rwe = 1; rdst = (op == 0) ? 2'd1 : 2'd0; done = 1; end
      S_MEM_ADDR: begin asel = 1; bsel = 2; aop = 3'b010; end
      S_MEM_RD:   begin mrd = 1; iord = 1; end
      S_MEM_WB:   begin rwe = 1; wb = 1; done = 1; end
      S_MEM_WR:   begin mwe = 1; iord = 1; done = rdy; end
      S_BRANCH:   begin asel = 1; aop = 3'b110; psrc = 1; pc_we = z; done = 1; end
      S_JUMP:     begin psrc = 2; pc_we = 1; done = 1; end
      S_JAL:      begin psrc = 2; pc_we = 1; rwe = 1; rdst = 2; wb = 2; done = 1; end
      S_JR:       begin psrc = 3; pc_we = 1; done = 1; end
      S_TRAP:     ill = 1;
      default:    ;
    endcase
    return {pc_we, ir_we, mrd, mwe, iord, rwe, rdst, wb, asel, bsel, aop, ext, psrc, done, ill};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive mem_ready, compare at negedge, advance past the next posedge
  task automatic step(int s, logic rdy);
    logic [20:0] e;
    bus.mem_ready = rdy;
    @(negedge clk);
    e = model(s, bus.opcode, bus.funct, bus.zero, rdy);
    trace.push_back(int'(bus.state));
    snap[s] = dut_outs();
    chk("state", 32'(bus.state), 32'(s));
    chk("outputs", 32'(dut_outs()), 32'(e));
    chk("instr_count", bus.instr_count, exp_count);
    @(posedge clk);
    #1;
    if (e[1]) exp_count = exp_count + 32'd1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(logic [5:0] op, logic [5:0] fn, logic z, int fst, int mst, output int cycles);
    int n0;
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    n0 = trace.size();
    for (int i = 0; i < fst; i++) step(S_FETCH, 1'b0);
    step(S_FETCH, 1'b1);
    step(S_DECODE, rnd());
    if (op == 6'h00 && fn == 6'h08) step(S_JR, rnd());
    else if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23 || fn == 6'h00)) begin
      step(S_EXEC_R, rnd()); step(S_ALU_WB, rnd());
    end else if (op == 6'h0D || op == 6'h0F) begin
      step(S_EXEC_I, rnd()); step(S_ALU_WB, rnd());
    end else if (op == 6'h23) begin
      step(S_MEM_ADDR, rnd());
      for (int i = 0; i < mst; i++) step(S_MEM_RD, 1'b0);
      step(S_MEM_RD, 1'b1);
      step(S_MEM_WB, rnd());
    end else if (op == 6'h2B) begin
      step(S_MEM_ADDR, rnd());
      for (int i = 0; i < mst; i++) step(S_MEM_WR, 1'b0);
      step(S_MEM_WR, 1'b1);
    end else if (op == 6'h04) step(S_BRANCH, rnd());
    else if (op == 6'h02) step(S_JUMP, rnd());
    else if (op == 6'h03) step(S_JAL, rnd());
    else for (int i = 0; i < 11; i++) step(S_TRAP, rnd());
    cycles = trace.size() - n0;
  endtask

  int cyc;

  initial begin
    checks = 0; errors = 0; exp_count = 0;
    rst_n = 1'b0;
    bus.opcode = 0; bus.funct = 0; bus.zero = 0; bus.mem_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_outputs", 32'(dut_outs()), 32'd0);
    chk("reset_count", bus.instr_count, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // addu straight after reset
    trace.delete();
    step(S_IDLE, 1'b1);
    run_instr(6'h00, 6'h21, 0, 0, 0, cyc);
    chk("addu_trace_len", 32'(trace.size()), 32'd5);
    if (trace.size() == 5) begin
      chk("addu_seq0", 32'(trace[0]), 32'd0);
      chk("addu_seq1", 32'(trace[1]), 32'd1);
      chk("addu_seq2", 32'(trace[2]), 32'd2);
      chk("addu_seq3", 32'(trace[3]), 32'd3);
      chk("addu_seq4", 32'(trace[4]), 32'd5);
    end
    chk("addu_then_fetch", 32'(bus.state), 32'd1);
    chk("addu_wb_regwe", 32'(snap[S_ALU_WB][15]), 32'd1);
    chk("addu_wb_regdst", 32'(snap[S_ALU_WB][14:13]), 32'd1);
    chk("addu_count", bus.instr_count, 32'd1);
    chk("addu_cycles", 32'(cyc), 32'd4);

    run_instr(6'h00, 6'h23, 0, 2, 0, cyc);
    chk("subu_stall_cycles", 32'(cyc), 32'd6);
    run_instr(6'h00, 6'h00, 0, 0, 0, cyc);
    run_instr(6'h0D, 6'h15, 0, 0, 0, cyc);
    run_instr(6'h0F, 6'h3F, 0, 1, 0, cyc);
    chk("lui_exec_b_sel", 32'(snap[S_EXEC_I][9:8]), 32'd2);

    run_instr(6'h23, 6'h00, 0, 0, 3, cyc);
    chk("lw_stall_cycles", 32'(cyc), 32'd8);
    chk("lw_memrd_rd_iord", 32'(snap[S_MEM_RD][18:16]), 32'b101);
    chk("lw_wb_sel", 32'(snap[S_MEM_WB][12:11]), 32'd1);
    chk("count_after_lw", bus.instr_count, 32'd6);

    run_instr(6'h2B, 6'h00, 0, 0, 0, cyc);
    chk("sw_cycles", 32'(cyc), 32'd4);
    run_instr(6'h2B, 6'h00, 0, 0, 2, cyc);

    run_instr(6'h04, 6'h00, 1, 0, 0, cyc);
    chk("beq_taken_pcwe", 32'(snap[S_BRANCH][20]), 32'd1);
    chk("beq_taken_pcsrc", 32'(snap[S_BRANCH][3:2]), 32'd1);
    chk("beq_taken_done", 32'(snap[S_BRANCH][1]), 32'd1);
    chk("beq_cycles", 32'(cyc), 32'd3);
    run_instr(6'h04, 6'h00, 0, 0, 0, cyc);
    chk("beq_nt_pcwe", 32'(snap[S_BRANCH][20]), 32'd0);
    chk("beq_nt_done", 32'(snap[S_BRANCH][1]), 32'd1);

    run_instr(6'h03, 6'h00, 0, 0, 0, cyc);
    chk("jal_regdst", 32'(snap[S_JAL][14:13]), 32'd2);
    chk("jal_wbsel", 32'(snap[S_JAL][12:11]), 32'd2);
    chk("jal_pcsrc", 32'(snap[S_JAL][3:2]), 32'd2);
    chk("jal_pcwe_regwe", 32'({snap[S_JAL][20], snap[S_JAL][15]}), 32'b11);
    chk("jal_cycles", 32'(cyc), 32'd3);
    run_instr(6'h00, 6'h08, 0, 0, 0, cyc);
    chk("jr_pcsrc", 32'(snap[S_JR][3:2]), 32'd3);
    chk("count_after_jr", bus.instr_count, 32'd12);

    // Counter wrap
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    exp_count = 32'hFFFF_FFFF;
    run_instr(6'h02, 6'h00, 0, 0, 0, cyc);
    chk("wrap_count", bus.instr_count, 32'd0);

    // Reset in the middle of a stalled store
    bus.opcode = 6'h2B;
    step(S_FETCH, 1'b1);
    step(S_DECODE, 1'b0);
    step(S_MEM_ADDR, 1'b0);
    step(S_MEM_WR, 1'b0);
    bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(bus.state), 32'd0);
    chk("midrst_outputs", 32'(dut_outs()), 32'd0);
    chk("midrst_count", bus.instr_count, 32'd0);
    exp_count = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(S_IDLE, 1'b0);

    // Undecodable opcode, then recover with a reset pulse
    run_instr(6'h3F, 6'h00, 0, 0, 0, cyc);
    chk("trap_illegal", 32'(bus.illegal), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("trap_rst_state", 32'(bus.state), 32'd0);
    chk("trap_rst_illegal", 32'(bus.illegal), 32'd0);
    exp_count = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(S_IDLE, 1'b1);
    run_instr(6'h00, 6'h3F, 0, 0, 0, cyc);
    chk("trap_funct_illegal", 32'(bus.illegal), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the MIPS core's shared datapath: one ALU, one unified memory port, one register file. It steps each instruction through fetch, decode, execute, memory and writeback states and drives every datapath select and enable. It stalls on a memory ready handshake and counts retired instructions. It supports the core's instruction set: addu, subu, sll, jr, ori, lui, lw, sw, beq, j, jal.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26]; valid from DECODE onward
- funct  input  6  IR[5:0]
- zero  input  1  ALU result == 0
- mem_ready  input  1  memory completes the current rd/wr this cycle
- pc_we  output  1  PC write enable
- ir_we  output  1  IR (and MDR) load
- mem_rd, mem_we  output  1 each  memory read / write request
- iord  output  1  memory address: 0 = PC, 1 = ALUOut
- reg_we  output  1  register file write
- reg_dst  output  2  0 = rt, 1 = rd, 2 = $31
- wb_sel  output  2  0 = ALUOut, 1 = MDR, 2 = PC
- alu_a_sel  output  1  0 = PC, 1 = A register
- alu_b_sel  output  2  0 = B, 1 = constant 4, 2 = ext(imm), 3 = ext(imm) << 2
- alu_op  output  3  000 none, 010 add, 110 sub, 001 or, 111 lui, 011 sll
- ext_op  output  1  1 = zero-extend, 0 = sign-extend
- pc_src  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = A (rs)
- instr_done  output  1  one-cycle retire pulse
- illegal  output  1  sticky undecodable-instruction flag
- state  output  4  current state, for debug
- instr_count  output  32  retired-instruction counter

## Operation
- State encoding: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, ALU_WB 5, MEM_ADDR 6, MEM_RD 7, MEM_WB 8, MEM_WR 9, BRANCH 10, JUMP 11, JAL 12, JR 13, TRAP 14.
- Outputs are combinational from state, opcode/funct, zero and mem_ready. Any output not listed for a state is 0.
- IDLE: all outputs 0. Unconditionally goes to FETCH.
- FETCH:
  - Asserts mem_rd=1, iord=0, alu_a_sel=0, alu_b_sel=1, alu_op=010, pc_src=0.
  - pc_we = ir_we = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Asserts alu_a_sel=0, alu_b_sel=3, alu_op=010, ext_op=0. This latches the branch target into ALUOut.
  - Next state by instruction:
    - opcode 0: funct 0x21, 0x23 or 0x00 go to EXEC_R; funct 0x08 goes to JR.
    - 0x0D (ori) and 0x0F (lui) go to EXEC_I.
    - 0x23 (lw) and 0x2B (sw) go to MEM_ADDR.
    - 0x04 goes to BRANCH; 0x02 goes to JUMP; 0x03 goes to JAL.
    - Anything else goes to TRAP.
- EXEC_R: alu_a_sel=1, alu_b_sel=0. alu_op is 010 for addu, 110 for subu, 011 for sll. Goes to ALU_WB.
- EXEC_I: alu_a_sel=1, alu_b_sel=2. ori uses alu_op=001, ext_op=1. lui uses alu_op=111, ext_op=0. Goes to ALU_WB.
- ALU_WB: reg_we=1, wb_sel=0. reg_dst=1 if opcode==0, else 0. instr_done=1. Goes to FETCH.
- MEM_ADDR: alu_a_sel=1, alu_b_sel=2, ext_op=0, alu_op=010. lw goes to MEM_RD; sw goes to MEM_WR.
- MEM_RD: mem_rd=1, iord=1, ir_we=0. The MDR loads every cycle. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: reg_we=1, reg_dst=0, wb_sel=1, instr_done=1. Goes to FETCH.
- MEM_WR: mem_we=1, iord=1. Waits for mem_ready. On mem_ready, instr_done=1 and goes to FETCH.
- BRANCH: alu_a_sel=1, alu_b_sel=0, alu_op=110, pc_src=1, pc_we=zero, instr_done=1. Goes to FETCH.
- JUMP: pc_src=2, pc_we=1, instr_done=1. Goes to FETCH.
- JAL: pc_src=2, pc_we=1, reg_we=1, reg_dst=2, wb_sel=2, instr_done=1. Goes to FETCH. The PC still holds PC+4 when written to $31.
- JR: pc_src=3, pc_we=1, instr_done=1. Goes to FETCH.
- TRAP: illegal=1. All enables are 0. TRAP is absorbing; only rst_n exits it.
- instr_count increments by 1 in each cycle where instr_done=1. It wraps from 0xFFFFFFFF to 0x00000000.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, instr_count=0. All outputs read 0, including illegal.
- The first FETCH occurs in the second clock edge's cycle after rst_n deasserts.
- Cycles per instruction with mem_ready tied high:
  - addu, subu, sll, ori, lui: 4
  - lw: 5
  - sw: 4
  - beq, j, jal, jr: 3
- Each cycle with mem_ready low adds 1 cycle in FETCH, MEM_RD or MEM_WR.
- mem_rd and mem_we remain asserted, with iord stable, until the cycle in which mem_ready=1.
- mem_ready is ignored in every other state.
- Never assert mem_rd and mem_we together. Never assert pc_we outside FETCH, BRANCH, JUMP, JAL and JR.
- Reset asserted mid-instruction aborts the instruction immediately: no retire, instr_count cleared.

## Test plan
- Reset, then addu (op 0, funct 0x21) with mem_ready=1:
  - State sequence 0,1,2,3,5,1.
  - ALU_WB shows reg_we=1, reg_dst=1.
  - instr_count = 1 after ALU_WB.
- lw with mem_ready low for 3 cycles in MEM_RD:
  - MEM_RD lasts 4 cycles with mem_rd=1, iord=1.
  - Retires on cycle 8 after FETCH entry.
  - MEM_WB shows wb_sel=1.
- beq:
  - zero=1 gives pc_we=1, pc_src=1 in BRANCH.
  - zero=0 gives pc_we=0.
  - instr_done=1 in both cases.
- jal:
  - JAL state shows reg_dst=2, wb_sel=2, pc_src=2, pc_we=1, reg_we=1.
  - 3 cycles total.
- Opcode 0x3F, then run 10 more cycles:
  - Stays in state 14 with illegal=1 and no enables asserted.
  - rst_n pulse low returns to state 0 with illegal=0.
- Preset instr_count to 0xFFFFFFFF (force), then retire j:
  - instr_count = 0.
  - rst_n asserted mid-MEM_WR gives all outputs 0 immediately.
